// File: rtl/cache_refill_ctrl.sv
// L1 cache line refill / write-back controller toward a burst memory port.
// Optional feature: define REFILL_CRITICAL_WORD_FIRST_EN for critical-word-first refills.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input  logic                                      sys_clk,
    input  logic                                      sys_rst_n,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic                                      req_write,
    input  logic [DATA_ADDR_WIDTH-1:0]                req_addr,
    output logic                                      fill_valid,
    output logic [$clog2(READ_BURST_LEN)-1:0]         fill_idx,
    output logic [DATA_WIDTH-1:0]                     fill_data,
    output logic                                      fill_last,
    output logic [$clog2(WRITE_BURST_LEN)-1:0]        wb_rd_idx,
    input  logic [DATA_WIDTH-1:0]                     wb_rd_data,
    output logic                                      done,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_ready,
    output logic                                      mem_req_write,
    output logic [DATA_ADDR_WIDTH-1:0]                mem_req_addr,
    input  logic                                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                     mem_rdata,
    output logic                                      mem_wvalid,
    input  logic                                      mem_wready,
    output logic [DATA_WIDTH-1:0]                     mem_wdata,
    output logic                                      mem_wlast
);

    localparam int RIDX_W      = $clog2(READ_BURST_LEN);
    localparam int WIDX_W      = $clog2(WRITE_BURST_LEN);
    localparam int AW          = DATA_ADDR_WIDTH;
    localparam int WORD_OFF    = $clog2(DATA_WIDTH / 8);
    localparam int RD_LINE_OFF = $clog2(READ_BURST_LEN * DATA_WIDTH / 8);
    localparam int WR_LINE_OFF = $clog2(WRITE_BURST_LEN * DATA_WIDTH / 8);

    localparam logic [AW-1:0] WORD_MASK = ~((AW'(1) << WORD_OFF) - AW'(1));
    localparam logic [AW-1:0] RD_MASK   = ~((AW'(1) << RD_LINE_OFF) - AW'(1));
    localparam logic [AW-1:0] WR_MASK   = ~((AW'(1) << WR_LINE_OFF) - AW'(1));

    localparam logic [RIDX_W-1:0] RD_LAST = RIDX_W'(READ_BURST_LEN - 1);
    localparam logic [WIDX_W-1:0] WR_LAST = WIDX_W'(WRITE_BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic [AW-1:0]       r_addr;
    logic [RIDX_W-1:0]   r_rd_cnt;
    logic [WIDX_W-1:0]   r_wr_cnt;

    logic                w_accept;
    logic                w_rd_adv;
    logic                w_wr_adv;
    logic [AW-1:0]       w_rd_addr;
    logic [AW-1:0]       w_wr_addr;
    logic [RIDX_W-1:0]   w_rd_start;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign w_rd_addr  = r_addr & WORD_MASK;
    assign w_rd_start = r_addr[WORD_OFF +: RIDX_W];
`else
    assign w_rd_addr  = r_addr & RD_MASK;
    assign w_rd_start = '0;
`endif
    assign w_wr_addr = r_addr & WR_MASK;
    assign w_accept  = (r_state == IDLE) && req_valid;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Captured request fields and beat counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end
            if (w_rd_adv) begin
                r_rd_cnt <= r_rd_cnt + RIDX_W'(1);
            end
            if (w_wr_adv) begin
                r_wr_cnt <= r_wr_cnt + WIDX_W'(1);
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next        = r_state;
        w_rd_adv      = 1'b0;
        w_wr_adv      = 1'b0;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        fill_valid    = 1'b0;
        fill_idx      = '0;
        fill_data     = '0;
        fill_last     = 1'b0;
        wb_rd_idx     = '0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        mem_wlast     = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_write ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                mem_req_valid = 1'b1;
                mem_req_write = r_write;
                mem_req_addr  = w_rd_addr;
                if (mem_req_ready) begin
                    w_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    fill_valid = 1'b1;
                    fill_idx   = w_rd_start + r_rd_cnt;
                    fill_data  = mem_rdata;
                    fill_last  = (r_rd_cnt == RD_LAST);
                    w_rd_adv   = 1'b1;
                    if (r_rd_cnt == RD_LAST) begin
                        w_next = DONE;
                    end
                end
            end
            WR_ADDR: begin
                mem_req_valid = 1'b1;
                mem_req_write = r_write;
                mem_req_addr  = w_wr_addr;
                if (mem_req_ready) begin
                    w_next = WR_DATA;
                end
            end
            WR_DATA: begin
                mem_wvalid = 1'b1;
                wb_rd_idx  = r_wr_cnt;
                mem_wdata  = wb_rd_data;
                mem_wlast  = (r_wr_cnt == WR_LAST);
                if (mem_wready) begin
                    w_wr_adv = 1'b1;
                    if (r_wr_cnt == WR_LAST) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized directed bench for cache_refill_ctrl.
// Expected values come from arithmetic on the request address and beat count.
module tb_cache_refill_ctrl;

    localparam int LINE_BYTES = 32;
    localparam int BEATS      = 8;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        fill_valid;
    logic [2:0]  fill_idx;
    logic [31:0] fill_data;
    logic        fill_last;
    logic [2:0]  wb_rd_idx;
    logic [31:0] wb_rd_data;
    logic        done;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_wdata;
    logic        mem_wlast;

    logic [31:0] wb_line [BEATS];
    int          n_checks;
    int          n_errors;

    cache_refill_ctrl dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .fill_valid    (fill_valid),
        .fill_idx      (fill_idx),
        .fill_data     (fill_data),
        .fill_last     (fill_last),
        .wb_rd_idx     (wb_rd_idx),
        .wb_rd_data    (wb_rd_data),
        .done          (done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_wdata     (mem_wdata),
        .mem_wlast     (mem_wlast)
    );

    // L1 data array answers write-back reads combinationally
    assign wb_rd_data = wb_line[wb_rd_idx];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] exp_rd_addr(input logic [31:0] a);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        return a - (a % 4);
`else
        return a - (a % LINE_BYTES);
`endif
    endfunction

    function automatic int exp_rd_start(input logic [31:0] a);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        return int'((a % LINE_BYTES) / 4);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] exp_wr_addr(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refill(input logic [31:0] a, input int dly,
                          input bit hold_next, input logic [31:0] next_a,
                          input bit stray, input int rst_at);
        int k;
        int guard;
        int start;
        start = exp_rd_start(a);
        @(negedge sys_clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        #1;
        chk("rd_accept_ready", req_ready, 1);
        chk("rd_idle_done", done, 0);
        for (int c = 0; c <= dly; c++) begin
            @(negedge sys_clk);
            if (hold_next) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = next_a;
            end else begin
                req_valid = 1'b0;
            end
            mem_req_ready = (c == dly);
            mem_rvalid    = stray;
            mem_rdata     = $urandom;
            #1;
            chk("rd_addr_valid", mem_req_valid, 1);
            chk("rd_addr", mem_req_addr, exp_rd_addr(a));
            chk("rd_addr_write", mem_req_write, 0);
            chk("rd_busy_ready", req_ready, 0);
            chk("rd_stray_fill", fill_valid, 0);
        end
        k = 0;
        guard = 0;
        while (k < BEATS && guard < 100) begin
            @(negedge sys_clk);
            guard++;
            mem_req_ready = 1'b0;
            if (rst_at == k) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                sys_rst_n  = 1'b0;
                #1;
                chk("rst_fill_valid", fill_valid, 0);
                chk("rst_fill_last", fill_last, 0);
                chk("rst_done", done, 0);
                chk("rst_mem_req_valid", mem_req_valid, 0);
                chk("rst_mem_wvalid", mem_wvalid, 0);
                chk("rst_req_ready", req_ready, 1);
                mem_rvalid = 1'b0;
                req_valid  = 1'b0;
                return;
            end
            mem_rvalid = ($urandom_range(0, 3) != 0);
            mem_rdata  = $urandom;
            #1;
            chk("rd_fill_valid", fill_valid, mem_rvalid);
            chk("rd_busy_ready", req_ready, 0);
            if (mem_rvalid) begin
                chk("rd_fill_idx", fill_idx, (start + k) % BEATS);
                chk("rd_fill_data", fill_data, mem_rdata);
                chk("rd_fill_last", fill_last, k == BEATS - 1);
                k++;
            end
        end
        if (k < BEATS) chk("rd_timeout", k, BEATS);
        @(negedge sys_clk);
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        #1;
        chk("rd_done", done, 1);
        chk("rd_done_fill", fill_valid, 0);
        chk("rd_done_ready", req_ready, 0);
        mem_rvalid = 1'b0;
    endtask

    task automatic writeback(input logic [31:0] a, input int dly,
                             input bit rand_ready);
        int k;
        int t;
        int guard;
        @(negedge sys_clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        for (int i = 0; i < BEATS; i++) wb_line[i] = $urandom;
        #1;
        chk("wb_accept_ready", req_ready, 1);
        chk("wb_idle_done", done, 0);
        for (int c = 0; c <= dly; c++) begin
            @(negedge sys_clk);
            req_valid     = 1'b0;
            mem_req_ready = (c == dly);
            mem_wready    = 1'b1;
            #1;
            chk("wb_addr_valid", mem_req_valid, 1);
            chk("wb_addr", mem_req_addr, exp_wr_addr(a));
            chk("wb_addr_write", mem_req_write, 1);
            chk("wb_addr_wvalid", mem_wvalid, 0);
        end
        k = 0;
        t = 0;
        guard = 0;
        while (k < BEATS && guard < 100) begin
            @(negedge sys_clk);
            guard++;
            mem_req_ready = 1'b0;
            mem_wready = rand_ready ? 1'($urandom_range(0, 1)) : (t % 2 == 0);
            t++;
            #1;
            chk("wb_wvalid", mem_wvalid, 1);
            chk("wb_rd_idx", wb_rd_idx, k);
            chk("wb_wdata", mem_wdata, wb_line[k]);
            chk("wb_wlast", mem_wlast, k == BEATS - 1);
            if (mem_wready) k++;
        end
        if (k < BEATS) chk("wb_timeout", k, BEATS);
        @(negedge sys_clk);
        mem_wready = 1'b1;
        #1;
        chk("wb_done", done, 1);
        chk("wb_done_wvalid", mem_wvalid, 0);
        chk("wb_done_wlast", mem_wlast, 0);
        mem_wready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        n_checks      = 0;
        n_errors      = 0;
        sys_rst_n     = 1'b0;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        mem_wready    = 1'b0;
        for (int i = 0; i < BEATS; i++) wb_line[i] = '0;

        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_mem_req_addr", mem_req_addr, 0);
        chk("reset_fill_valid", fill_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_mem_wvalid", mem_wvalid, 0);
        chk("reset_mem_wlast", mem_wlast, 0);
        sys_rst_n = 1'b1;

        refill(32'h40, 3, 1'b0, 32'h0, 1'b0, -1);
        writeback(32'h8C, 0, 1'b0);
        refill(32'h4C, 1, 1'b0, 32'h0, 1'b0, -1);

        refill(32'h120, 0, 1'b0, 32'h0, 1'b0, 4);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        refill(32'h24, 2, 1'b0, 32'h0, 1'b0, -1);

        refill(32'h60, 2, 1'b1, 32'h1A4, 1'b1, -1);
        writeback(32'h1A4, 1, 1'b1);

        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                writeback(a, $urandom_range(0, 3), 1'b1);
            end else begin
                refill(a, $urandom_range(0, 3), 1'b0, 32'h0, 1'b0, -1);
            end
        end

        @(negedge sys_clk);
        #1;
        chk("final_req_ready", req_ready, 1);
        chk("final_done", done, 0);
        chk("final_mem_req_valid", mem_req_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
